// File: rtl/tape_pkg.sv
// Shared types and constants for the photo tape reader sequencer.
package tape_pkg;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_BACKUP = 2'd1,
    OP_REWIND = 2'd2,
    OP_ABORT  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_OK          = 3'd0,
    ST_START_TO    = 3'd1,
    ST_END_OF_TAPE = 3'd2,
    ST_OVERRUN     = 3'd3,
    ST_ABORTED     = 3'd4
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_STOPPING
  } state_e;

  localparam logic [4:0] STOP_CODE_DEF = 5'h10;

endpackage

// File: rtl/tape_char_decode.sv
// Photo-line sampler: one character per mark, blank-tape idle timer.
module tape_char_decode #(
  parameter int IDLE_TIMEOUT_MS = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       tick,
  input  logic [4:0] photo,
  output logic       new_char,
  output logic [4:0] char,
  output logic       idle_timeout
);

  localparam logic [15:0] IDLE_LIM = 16'(IDLE_TIMEOUT_MS);

  logic [4:0]  prev_q;
  logic        held_q;
  logic [15:0] idle_q;
  logic        sample;

  assign sample       = en & tick;
  // A mark must be seen on two consecutive ticks; the held flag blocks repeats until a blank.
  assign new_char     = sample && (photo != 5'd0) && (photo == prev_q) && !held_q;
  assign char         = photo;
  assign idle_timeout = sample && !new_char && ((idle_q + 16'd1) == IDLE_LIM);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      prev_q <= 5'd0;
      held_q <= 1'b0;
      idle_q <= 16'd0;
    end else if (tick) begin
      prev_q <= photo;
      if (photo == 5'd0)
        held_q <= 1'b0;
      else if (new_char)
        held_q <= 1'b1;
      idle_q <= new_char ? 16'd0 : idle_q + 16'd1;
    end
  end

endmodule

// File: rtl/tape_reader_ctl.sv
// Block-level photo tape reader sequencer (READ/BACKUP/REWIND/ABORT).
// Optional block statistics outputs enabled by TAPE_READER_CTL_STATS_EN.
module tape_reader_ctl
  import tape_pkg::*;
#(
  parameter logic [4:0] STOP_CODE        = STOP_CODE_DEF,
  parameter int         START_TIMEOUT_MS = 50,
  parameter int         IDLE_TIMEOUT_MS  = 200,
  parameter int         MAX_CHARS        = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_ms,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  photo,
  input  logic        wait_for_tape,
  output logic        tape_fwd,
  output logic        tape_rev,
  output logic        remote_rewind,
  output logic        char_valid,
  output logic [4:0]  char_data,
  output logic        busy,
  output logic        done,
  output logic [2:0]  status
`ifdef TAPE_READER_CTL_STATS_EN
  ,
  output logic [15:0] blk_count,
  output logic [10:0] last_len
`endif
);

  localparam logic [15:0] START_LIM = 16'(START_TIMEOUT_MS);
  localparam logic [10:0] MAX_L     = 11'(MAX_CHARS);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  status_e     pend_q, pend_d;
  status_e     status_q, status_d;
  logic [15:0] ms_q, ms_d;
  logic        stop_seen_q, stop_seen_d;
  logic [10:0] ccnt_q, ccnt_d;
  logic        char_valid_q, char_valid_d;
  logic [4:0]  char_data_q, char_data_d;
  logic        done_q, done_d;
  logic        finish;
  logic        abort_req;
  logic        moving;
  logic        new_char;
  logic [4:0]  dec_char;
  logic        idle_timeout;
`ifdef TAPE_READER_CTL_STATS_EN
  logic [15:0] blk_q, blk_d;
  logic [10:0] last_q, last_d;
`endif

  tape_char_decode #(
    .IDLE_TIMEOUT_MS(IDLE_TIMEOUT_MS)
  ) u_dec (
    .clk         (clk),
    .rst         (rst),
    .en          (state_q == S_RUN),
    .tick        (tick_ms),
    .photo       (photo),
    .new_char    (new_char),
    .char        (dec_char),
    .idle_timeout(idle_timeout)
  );

  assign abort_req = cmd_valid && (op_e'(cmd_op) == OP_ABORT);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    pend_d       = pend_q;
    status_d     = status_q;
    ms_d         = ms_q;
    stop_seen_d  = stop_seen_q;
    ccnt_d       = ccnt_q;
    char_valid_d = 1'b0;
    char_data_d  = char_data_q;
    done_d       = 1'b0;
    finish       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (abort_req) begin
            done_d   = 1'b1;
            status_d = ST_ABORTED;
          end else begin
            op_d        = op_e'(cmd_op);
            state_d     = S_START;
            pend_d      = ST_OK;
            status_d    = ST_OK;
            ms_d        = 16'd0;
            stop_seen_d = 1'b0;
            ccnt_d      = 11'd0;
          end
        end
      end
      S_START: begin
        if (wait_for_tape) begin
          state_d = S_RUN;
          ms_d    = 16'd0;
        end else if (tick_ms) begin
          ms_d = ms_q + 16'd1;
          if ((ms_q + 16'd1) == START_LIM) begin
            state_d = S_STOPPING;
            pend_d  = ST_START_TO;
            ms_d    = 16'd0;
          end
        end
      end
      S_RUN: begin
        // A character clears the idle timer, so these two never fire together.
        if (idle_timeout) begin
          state_d = S_STOPPING;
          pend_d  = ST_END_OF_TAPE;
          ms_d    = 16'd0;
        end else if (new_char) begin
          case (op_q)
            OP_READ: begin
              if (dec_char == STOP_CODE) begin
                state_d = S_STOPPING;
                pend_d  = ST_OK;
                ms_d    = 16'd0;
              end else if (ccnt_q == MAX_L) begin
                state_d = S_STOPPING;
                pend_d  = ST_OVERRUN;
                ms_d    = 16'd0;
              end else begin
                char_valid_d = 1'b1;
                char_data_d  = dec_char;
                ccnt_d       = ccnt_q + 11'd1;
              end
            end
            OP_BACKUP: begin
              // First stop code belongs to the block just read; the second marks its start.
              if (dec_char == STOP_CODE) begin
                if (stop_seen_q) begin
                  state_d = S_STOPPING;
                  pend_d  = ST_OK;
                  ms_d    = 16'd0;
                end else begin
                  stop_seen_d = 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
      S_STOPPING: begin
        if (!wait_for_tape || (tick_ms && ((ms_q + 16'd1) == START_LIM))) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          finish   = 1'b1;
          status_d = abort_req ? ST_ABORTED : pend_q;
        end else begin
          if (abort_req)
            pend_d = ST_ABORTED;
          if (tick_ms)
            ms_d = ms_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_req && ((state_q == S_START) || (state_q == S_RUN))) begin
      state_d      = S_STOPPING;
      pend_d       = ST_ABORTED;
      ms_d         = 16'd0;
      char_valid_d = 1'b0;
      char_data_d  = char_data_q;
      ccnt_d       = ccnt_q;
      stop_seen_d  = stop_seen_q;
    end
  end

`ifdef TAPE_READER_CTL_STATS_EN
  always_comb begin
    blk_d  = blk_q;
    last_d = last_q;
    if (finish) begin
      case (op_q)
        OP_READ: begin
          last_d = ccnt_q;
          if (status_d == ST_OK)
            blk_d = blk_q + 16'd1;
        end
        OP_BACKUP: begin
          if ((status_d == ST_OK) && (blk_q != 16'd0))
            blk_d = blk_q - 16'd1;
        end
        OP_REWIND: blk_d = 16'd0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q  <= 16'd0;
      last_q <= 11'd0;
    end else begin
      blk_q  <= blk_d;
      last_q <= last_d;
    end
  end

  assign blk_count = blk_q;
  assign last_len  = last_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_READ;
      pend_q       <= ST_OK;
      status_q     <= ST_OK;
      ms_q         <= 16'd0;
      stop_seen_q  <= 1'b0;
      ccnt_q       <= 11'd0;
      char_valid_q <= 1'b0;
      char_data_q  <= 5'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      pend_q       <= pend_d;
      status_q     <= status_d;
      ms_q         <= ms_d;
      stop_seen_q  <= stop_seen_d;
      ccnt_q       <= ccnt_d;
      char_valid_q <= char_valid_d;
      char_data_q  <= char_data_d;
      done_q       <= done_d;
    end
  end

  // Motor lines decode straight from state, so only one can ever be high.
  assign moving        = (state_q == S_START) || (state_q == S_RUN);
  assign tape_fwd      = moving && (op_q == OP_READ);
  assign tape_rev      = moving && (op_q == OP_BACKUP);
  assign remote_rewind = moving && (op_q == OP_REWIND);
  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign char_valid    = char_valid_q;
  assign char_data     = char_data_q;
  assign done          = done_q;
  assign status        = status_q;

endmodule

// File: tb/tb_tape_reader_ctl.sv
// Scoreboard bench for tape_reader_ctl with a behavioural tape/reader model.
module tb_tape_reader_ctl;

  localparam int TICK_CLKS = 4;
  localparam logic [4:0] STOP = 5'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_ms = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [4:0]  photo = 5'd0;
  logic        wait_for_tape = 1'b0;
  logic        cmd_ready, tape_fwd, tape_rev, remote_rewind;
  logic        char_valid, busy, done;
  logic [4:0]  char_data;
  logic [2:0]  status;
`ifdef TAPE_READER_CTL_STATS_EN
  logic [15:0] blk_count;
  logic [10:0] last_len;
  int          blk_model = 0;
`endif

  tape_reader_ctl dut (
    .clk          (clk),
    .rst          (rst),
    .tick_ms      (tick_ms),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .photo        (photo),
    .wait_for_tape(wait_for_tape),
    .tape_fwd     (tape_fwd),
    .tape_rev     (tape_rev),
    .remote_rewind(remote_rewind),
    .char_valid   (char_valid),
    .char_data    (char_data),
    .busy         (busy),
    .done         (done),
    .status       (status)
`ifdef TAPE_READER_CTL_STATS_EN
    ,
    .blk_count    (blk_count),
    .last_len     (last_len)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [4:0] exp_chars[$];
  logic [2:0] exp_status[$];
  int done_cnt = 0;
  int both_cnt = 0;

  logic [4:0] frames[$];
  int rise_ms = 1;
  int tdiv = 0;
  int mot_ms = 0;
  int last_mot_ms = 0;
  int slot = 0;
  int drop_ms = 0;

  // Tape: each frame is 3 ms of mark then 2 ms of blank; blank after the last frame.
  function automatic logic [4:0] slot_val(int s);
    int k;
    k = s / 5;
    if ((s % 5) < 3 && k < frames.size()) return frames[k];
    return 5'd0;
  endfunction

  always @(negedge clk) begin
    logic motor;
    motor = tape_fwd | tape_rev | remote_rewind;
    tdiv = (tdiv + 1) % TICK_CLKS;
    tick_ms = (tdiv == 0);
    photo = 5'd0;
    if (!motor) begin
      mot_ms = 0;
      slot = 0;
    end
    if (tick_ms) begin
      if (motor) begin
        if (wait_for_tape) begin
          photo = slot_val(slot);
          slot++;
        end
        mot_ms++;
        last_mot_ms = mot_ms;
        if (!wait_for_tape && rise_ms > 0 && mot_ms == rise_ms) wait_for_tape = 1'b1;
        drop_ms = 0;
      end else if (wait_for_tape) begin
        drop_ms++;
        if (drop_ms == 3) begin
          wait_for_tape = 1'b0;
          drop_ms = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] ec;
    logic [2:0] es;
    if (tape_fwd && tape_rev) both_cnt++;
    if (!rst && char_valid) begin
      vectors++;
      if (exp_chars.size() == 0) begin
        miscompares++;
        $display("FAIL char_extra: got char_data=%02h, required no character", char_data);
      end else begin
        ec = exp_chars.pop_front();
        if (char_data !== ec) begin
          miscompares++;
          $display("FAIL char_data: got %02h, required %02h", char_data, ec);
        end
      end
    end
    if (!rst && done) begin
      done_cnt++;
      vectors++;
      if (exp_status.size() == 0) begin
        miscompares++;
        $display("FAIL done_extra: got status=%0d, required no completion", status);
      end else begin
        es = exp_status.pop_front();
        if (status !== es) begin
          miscompares++;
          $display("FAIL status: got %0d, required %0d", status, es);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: expected characters and final status from the tape contents alone.
  task automatic model(input int op, input int rise, input int abort_slot);
    int st;
    int n;
    int stops;
    bit fin;
    n = 0;
    stops = 0;
    fin = 0;
    st = 2;
    if (rise == 0) begin
      st = 1;
    end else if (abort_slot >= 0) begin
      if (op == 0)
        for (int k = 0; k < frames.size() && (5 * k + 1) <= abort_slot - 1; k++)
          exp_chars.push_back(frames[k]);
      st = 4;
    end else if (op == 0) begin
      for (int k = 0; k < frames.size() && !fin; k++) begin
        if (frames[k] == STOP) begin
          st = 0; fin = 1;
        end else if (n == 1024) begin
          st = 3; fin = 1;
        end else begin
          exp_chars.push_back(frames[k]);
          n++;
        end
      end
    end else if (op == 1) begin
      for (int k = 0; k < frames.size() && !fin; k++)
        if (frames[k] == STOP) begin
          stops++;
          if (stops == 2) begin
            st = 0; fin = 1;
          end
        end
    end
    exp_status.push_back(3'(st));
`ifdef TAPE_READER_CTL_STATS_EN
    if (op == 0 && st == 0) blk_model++;
    if (op == 1 && st == 0 && blk_model > 0) blk_model--;
    if (op == 2) blk_model = 0;
`endif
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (wait_for_tape && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (wait_for_tape) begin
      vectors++; miscompares++;
      $display("FAIL tape_settle: got wait_for_tape=1, required 0");
    end
  endtask

  task automatic run_cmd(input int op, input int rise, input int abort_slot, input int budget);
    int n;
    int d0;
    settle();
    rise_ms = rise;
    model(op, rise, abort_slot);
    d0 = done_cnt;
    cmd_op = 2'(op);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_op = (op == 2) ? 2'd0 : 2'd2;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (abort_slot >= 0) begin
      n = 0;
      while (slot < abort_slot && n < budget) begin
        @(posedge clk); #1; n++;
      end
      if (slot < abort_slot) begin
        vectors++; miscompares++;
        $display("FAIL abort_wait: got slot=%0d, required %0d", slot, abort_slot);
      end
      cmd_op = 2'd3;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("abort_motor_drop", {29'd0, tape_fwd, tape_rev, remote_rewind}, 0);
    end
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1; n++;
    end
    if (done_cnt == d0) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: got no done after %0d clks, required done", budget);
    end
`ifdef TAPE_READER_CTL_STATS_EN
    check("blk_count", int'(blk_count), blk_model);
`endif
  endtask

  initial begin
    int d0;
    int op;
    int nf;
    int rise;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_busy_done", int'({busy, done, char_valid}), 0);
    check("rst_motors", int'({tape_fwd, tape_rev, remote_rewind}), 0);
    check("rst_status_char", int'({status, char_data}), 0);

    // ABORT from idle completes on the next clock.
    exp_status.push_back(3'd4);
    d0 = done_cnt;
    cmd_op = 2'd3; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("idle_abort_done", int'(done), 1);
    @(posedge clk); #1;
    check("idle_abort_count", done_cnt - d0, 1);

    frames = '{5'h05, 5'h1F, 5'h10};
    run_cmd(0, 20, -1, 5000);

    frames = '{5'h05};
    run_cmd(0, 0, -1, 5000);
    check("start_to_ms", last_mot_ms, 50);

    frames = '{5'h10, 5'h03, 5'h07, 5'h10};
    run_cmd(1, 10, -1, 5000);

    frames = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06};
    run_cmd(2, 5, -1, 5000);
    check("rewind_ms", last_mot_ms, 5 + 227);

    frames.delete();
    for (int j = 0; j < 8; j++) frames.push_back(5'($urandom_range(1, 15)));
    run_cmd(0, 3, 11, 5000);

    for (int i = 0; i < 10; i++) begin
      op = $urandom_range(0, 2);
      nf = $urandom_range(0, 10);
      frames.delete();
      for (int j = 0; j < nf; j++)
        frames.push_back(($urandom_range(0, 3) == 0) ? STOP : 5'($urandom_range(1, 31)));
      rise = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 45);
      run_cmd(op, rise, -1, 8000);
    end

    // Reset in the middle of a rewind drops the motor line at that edge.
    settle();
    frames = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06};
    rise_ms = 2;
    cmd_op = 2'd2; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int n = 0; n < 2000 && slot < 3; n++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_motor", int'({tape_fwd, tape_rev, remote_rewind}), 0);
    check("rst_mid_ready", int'(cmd_ready), 1);
    rst = 1'b0;
`ifdef TAPE_READER_CTL_STATS_EN
    blk_model = 0;
    frames = '{5'h05, 5'h10};
    run_cmd(0, 4, -1, 5000);
`endif

    frames.delete();
    for (int j = 0; j < 1025; j++) frames.push_back(5'($urandom_range(1, 15)));
    frames.push_back(STOP);
    run_cmd(0, 1, -1, 30000);
`ifdef TAPE_READER_CTL_STATS_EN
    check("last_len", int'(last_len), 1024);
`endif

    check("scoreboard_chars_left", exp_chars.size(), 0);
    check("scoreboard_status_left", exp_status.size(), 0);
    check("fwd_rev_overlap", both_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
